// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage: two-entry skid buffer (SKID=1) or single register (SKID=0), 1-cycle latency.
// SKID=1 in_ready is registered (no out_ready->in_ready path); SKID=0 in_ready follows out_ready; clr flushes and counts drops.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Two spare bits so the occupancy add cannot wrap before the saturation compare.
  localparam logic [CNT_W+1:0] DROP_MAX = {2'b00, {CNT_W{1'b1}}};

  logic [CNT_W+1:0] drop_sum;

  assign drop_sum = {2'b00, drop_cnt} + {{CNT_W{1'b0}}, occupancy};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (clr) begin
      drop_cnt <= (drop_sum > DROP_MAX) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      state_t            state_q;
      state_t            state_d;
      logic [DATA_W-1:0] main_q;
      logic [DATA_W-1:0] main_d;
      logic [DATA_W-1:0] skid_q;
      logic [DATA_W-1:0] skid_d;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
        end
      end

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (clr) begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end else begin
          case (state_q)
            EMPTY: begin
              if (in_xfer) begin
                main_d  = in_data;
                state_d = ONE;
              end
            end
            ONE: begin
              if (in_xfer && out_xfer) begin
                main_d = in_data;
              end else if (in_xfer) begin
                skid_d  = in_data;
                state_d = FULL;
              end else if (out_xfer) begin
                main_d  = '0;
                state_d = EMPTY;
              end
            end
            FULL: begin
              // in_ready is low here, so only the drain side can move.
              if (out_xfer) begin
                main_d  = skid_q;
                skid_d  = '0;
                state_d = ONE;
              end
            end
            default: begin
              state_d = EMPTY;
              main_d  = '0;
              skid_d  = '0;
            end
          endcase
        end
      end

      always_comb begin
        out_valid = (state_q != EMPTY);
        out_data  = (state_q != EMPTY) ? main_q : '0;
        in_ready  = rst_n && (state_q != FULL);
        case (state_q)
          ONE:     occupancy = 2'd1;
          FULL:    occupancy = 2'd2;
          default: occupancy = 2'd0;
        endcase
      end
    end else begin : g_reg
      logic              vld_q;
      logic [DATA_W-1:0] main_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q  <= 1'b0;
          main_q <= '0;
        end else if (clr) begin
          vld_q  <= 1'b0;
          main_q <= '0;
        end else if (in_xfer) begin
          vld_q  <= 1'b1;
          main_q <= in_data;
        end else if (out_xfer) begin
          vld_q  <= 1'b0;
          main_q <= '0;
        end
      end

      always_comb begin
        out_valid = vld_q;
        out_data  = vld_q ? main_q : '0;
        in_ready  = rst_n && (!vld_q || out_ready);
        occupancy = {1'b0, vld_q};
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid (CNT_W=2) and plain-register (CNT_W=4) instances share stimulus,
// checked against hand-written vectors and a queue-based reference model.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       s_in_ready, s_out_valid;
  logic [7:0] s_out_data;
  logic [1:0] s_occ;
  logic [1:0] s_drop;

  logic       r_in_ready, r_out_valid;
  logic [7:0] r_out_data;
  logic [1:0] r_occ;
  logic [3:0] r_drop;

  pipe_stage_reg #(.DATA_W(8), .SKID(1), .CNT_W(2)) u_skid (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .occupancy(s_occ), .drop_cnt(s_drop)
  );

  pipe_stage_reg #(.DATA_W(8), .SKID(0), .CNT_W(4)) u_reg (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(r_in_ready), .in_data(in_data),
    .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data),
    .occupancy(r_occ), .drop_cnt(r_drop)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: each stage is a FIFO of held payloads.
  logic [7:0] qs[$];
  logic [7:0] qr[$];
  int         drop_s, drop_r;
  logic       s_rdy_seen, r_rdy_seen;

  typedef struct {
    logic       c;
    logic       iv;
    logic [7:0] d;
    logic       o;
    logic       e_rdy;
    logic       e_ov;
    logic [7:0] e_od;
    logic [1:0] e_occ;
    logic [1:0] e_drop;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t v(input int c, iv, d, o, rdy, ov, od, occ, dr);
    vec_t t;
    t.c = c[0]; t.iv = iv[0]; t.d = d[7:0]; t.o = o[0];
    t.e_rdy = rdy[0]; t.e_ov = ov[0]; t.e_od = od[7:0];
    t.e_occ = occ[1:0]; t.e_drop = dr[1:0];
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit ixs, oxs, ixr, oxr;
    if (clr) begin
      drop_s = (drop_s + qs.size() > 3)  ? 3  : drop_s + qs.size();
      drop_r = (drop_r + qr.size() > 15) ? 15 : drop_r + qr.size();
      qs.delete();
      qr.delete();
    end else begin
      ixs = in_valid && (qs.size() < 2);
      oxs = (qs.size() > 0) && out_ready;
      ixr = in_valid && ((qr.size() == 0) || out_ready);
      oxr = (qr.size() > 0) && out_ready;
      if (oxs) void'(qs.pop_front());
      if (ixs) qs.push_back(in_data);
      if (oxr) void'(qr.pop_front());
      if (ixr) qr.push_back(in_data);
    end
  endtask

  task automatic check_outputs();
    logic [7:0] hs, hr;
    hs = 8'h00;
    hr = 8'h00;
    if (qs.size() > 0) hs = qs[0];
    if (qr.size() > 0) hr = qr[0];
    check("s_out_valid", s_out_valid, qs.size() > 0);
    check("s_out_data",  s_out_data,  hs);
    check("s_occupancy", s_occ,       qs.size());
    check("s_drop_cnt",  s_drop,      drop_s);
    check("r_out_valid", r_out_valid, qr.size() > 0);
    check("r_out_data",  r_out_data,  hr);
    check("r_occupancy", r_occ,       qr.size());
    check("r_drop_cnt",  r_drop,      drop_r);
  endtask

  task automatic step(input logic c, input logic iv, input logic [7:0] d, input logic o);
    clr = c; in_valid = iv; in_data = d; out_ready = o;
    #1;
    s_rdy_seen = s_in_ready;
    r_rdy_seen = r_in_ready;
    check("s_in_ready", s_in_ready, qs.size() < 2);
    check("r_in_ready", r_in_ready, (qr.size() == 0) || o);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    qs.delete();
    qr.delete();
    drop_s = 0;
    drop_r = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] sat_exp [4];
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3;

    //           c iv  d     o rdy ov od    occ drop
    tbl[0]  = v(0, 1, 'h01, 1, 1, 1, 'h01, 1, 0);
    tbl[1]  = v(0, 1, 'h02, 1, 1, 1, 'h02, 1, 0);
    tbl[2]  = v(0, 1, 'h03, 1, 1, 1, 'h03, 1, 0);
    tbl[3]  = v(0, 1, 'h04, 1, 1, 1, 'h04, 1, 0);
    tbl[4]  = v(0, 0, 'h00, 1, 1, 0, 'h00, 0, 0);
    tbl[5]  = v(0, 1, 'h0A, 0, 1, 1, 'h0A, 1, 0);
    tbl[6]  = v(0, 1, 'h0B, 0, 1, 1, 'h0A, 2, 0);
    tbl[7]  = v(0, 1, 'h0C, 0, 0, 1, 'h0A, 2, 0);
    tbl[8]  = v(0, 1, 'h0C, 1, 0, 1, 'h0B, 1, 0);
    tbl[9]  = v(0, 1, 'h0C, 1, 1, 1, 'h0C, 1, 0);
    tbl[10] = v(0, 0, 'h00, 1, 1, 0, 'h00, 0, 0);
    tbl[11] = v(0, 1, 'h0A, 0, 1, 1, 'h0A, 1, 0);
    tbl[12] = v(0, 1, 'h0B, 0, 1, 1, 'h0A, 2, 0);
    tbl[13] = v(1, 1, 'h0C, 0, 0, 0, 'h00, 0, 2);
    tbl[14] = v(0, 0, 'h00, 0, 1, 0, 'h00, 0, 2);
    tbl[15] = v(0, 1, 'h11, 0, 1, 1, 'h11, 1, 2);
    tbl[16] = v(1, 0, 'h00, 0, 1, 0, 'h00, 0, 3);
    tbl[17] = v(0, 1, 'h12, 1, 1, 1, 'h12, 1, 3);
    tbl[18] = v(1, 0, 'h00, 1, 1, 0, 'h00, 0, 3);
    tbl[19] = v(1, 1, 'h55, 1, 1, 0, 'h00, 0, 3);

    rst_n = 1'b0;
    clr = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    #2;
    check("rst_s_in_ready",  s_in_ready,  0);
    check("rst_s_out_valid", s_out_valid, 0);
    check("rst_s_out_data",  s_out_data,  0);
    check("rst_s_occ",       s_occ,       0);
    check("rst_s_drop",      s_drop,      0);
    check("rst_r_in_ready",  r_in_ready,  0);
    check("rst_r_out_valid", r_out_valid, 0);
    check("rst_r_occ",       r_occ,       0);

    // First row lands on the first edge after release.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].c, tbl[i].iv, tbl[i].d, tbl[i].o);
      check($sformatf("vec%0d_in_ready", i),  s_rdy_seen,  tbl[i].e_rdy);
      check($sformatf("vec%0d_out_valid", i), s_out_valid, tbl[i].e_ov);
      check($sformatf("vec%0d_out_data", i),  s_out_data,  tbl[i].e_od);
      check($sformatf("vec%0d_occ", i),       s_occ,       tbl[i].e_occ);
      check($sformatf("vec%0d_drop", i),      s_drop,      tbl[i].e_drop);
    end

    // Asynchronous reset between edges while the skid stage is full.
    step(1'b0, 1'b1, 8'hA1, 1'b0);
    step(1'b0, 1'b1, 8'hA2, 1'b0);
    check("full_before_arst", s_occ, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", s_out_valid, 0);
    check("arst_out_data",  s_out_data,  0);
    check("arst_occ",       s_occ,       0);
    check("arst_in_ready",  s_in_ready,  0);
    check("arst_drop",      s_drop,      0);
    check("arst_r_valid",   r_out_valid, 0);
    do_reset();

    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h20 + 8'(i), 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      check($sformatf("sat_drop%0d", i), s_drop, sat_exp[i]);
    end

    // Plain register: stall blocks input, simultaneous drain+fill replaces in one edge.
    step(1'b0, 1'b1, 8'h31, 1'b0);
    step(1'b0, 1'b1, 8'h32, 1'b0);
    check("reg_stall_in_ready", r_rdy_seen, 0);
    check("reg_stall_data",     r_out_data, 8'h31);
    step(1'b0, 1'b1, 8'h33, 1'b1);
    check("reg_pass_in_ready", r_rdy_seen,  1);
    check("reg_replace_data",  r_out_data,  8'h33);
    check("reg_replace_valid", r_out_valid, 1);

    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) begin
        #2;
        do_reset();
      end
      step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
           8'($urandom_range(0, 255)), $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
